// File: rtl/retospect_bs_loader.sv
// Configuration shift-chain feeder: serialises bytes into the neurochip chain
// and reads the chain back non-destructively as a byte stream.
module retospect_bs_loader #(
  parameter int CHAIN_LEN = 998,
  parameter int CNT_W     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_load,
  input  logic       start_read,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       cfg_en,
  output logic       cfg_bs_in,
  input  logic       cfg_bs_out,
  output logic       nn_reset,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, LD_FETCH, LD_SHIFT, LD_PULSE, RD_SHIFT, RD_EMIT
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(CHAIN_LEN);

  state_t           state, state_next;
  logic [7:0]       sreg, sreg_next;
  logic [3:0]       bitcnt, bitcnt_next;
  logic [CNT_W-1:0] total, total_next;
  logic             rd_done, rd_done_next;

  // NOTE: every sequential register, state included, is cleared by reset so
  // outputs decoded from them are defined from the first cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      bitcnt  <= '0;
      total   <= '0;
      rd_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state   <= state_next;
      sreg    <= sreg_next;
      bitcnt  <= bitcnt_next;
      total   <= total_next;
      rd_done <= rd_done_next;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through the case leaves a
    // variable unassigned and no latch is inferred.
    state_next   = state;
    sreg_next    = sreg;
    bitcnt_next  = bitcnt;
    total_next   = total;
    rd_done_next = 1'b0;

    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_load) begin
            state_next = LD_FETCH;
            total_next = '0;
          end else if (start_read) begin
            state_next  = RD_SHIFT;
            total_next  = '0;
            bitcnt_next = '0;
            sreg_next   = '0;
          end
        end
        LD_FETCH: begin
          if (in_valid) begin
            sreg_next   = in_data;
            bitcnt_next = '0;
            state_next  = LD_SHIFT;
          end
        end
        LD_SHIFT: begin
          sreg_next   = {1'b0, sreg[7:1]};
          bitcnt_next = bitcnt + 4'd1;
          total_next  = total + 1'b1;
          // The chain-length test wins so surplus bits of the last byte are dropped.
          if (total == LAST_BIT)  state_next = LD_PULSE;
          else if (bitcnt == 4'd7) state_next = LD_FETCH;
        end
        LD_PULSE: state_next = IDLE;
        RD_SHIFT: begin
          sreg_next[bitcnt[2:0]] = cfg_bs_out;
          bitcnt_next = bitcnt + 4'd1;
          total_next  = total + 1'b1;
          if (bitcnt == 4'd7 || total == LAST_BIT) state_next = RD_EMIT;
        end
        RD_EMIT: begin
          if (out_ready) begin
            if (total == FULL) begin
              rd_done_next = 1'b1;
              state_next   = IDLE;
            end else begin
              sreg_next   = '0;
              bitcnt_next = '0;
              state_next  = RD_SHIFT;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Readback recirculates the tail bit so the chain ends where it started.
  assign in_ready  = (state == LD_FETCH);
  assign cfg_en    = (state == LD_SHIFT) || (state == RD_SHIFT);
  assign cfg_bs_in = (state == LD_SHIFT) ? sreg[0] :
                     (state == RD_SHIFT) ? cfg_bs_out : 1'b0;
  assign out_valid = (state == RD_EMIT);
  assign out_data  = (state == RD_EMIT) ? sreg : 8'h00;
  assign nn_reset  = (state == LD_PULSE);
  assign busy      = (state != IDLE);
  assign done      = (state == LD_PULSE) || rd_done;

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Directed bench: short-chain load sequence, then full-length load, readback,
// abort, gapped load and reset against a behavioural chain model.
module tb_retospect_bs_loader;
  localparam int N  = 998;
  localparam int NB = 125;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_load, start_read, abort, in_valid, out_ready, cfg_bs_out;
  logic [7:0] in_data, out_data;
  logic       in_ready, out_valid, cfg_en, cfg_bs_in, nn_reset, busy, done;

  logic       start_load_s, start_read_s, in_valid_s;
  logic [7:0] in_data_s, out_data_s;
  logic       in_ready_s, out_valid_s, cfg_en_s, cfg_bs_in_s, nn_reset_s, busy_s, done_s;

  retospect_bs_loader dut (
    .clk(clk), .reset(reset), .start_load(start_load), .start_read(start_read),
    .abort(abort), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_en(cfg_en), .cfg_bs_in(cfg_bs_in), .cfg_bs_out(cfg_bs_out),
    .nn_reset(nn_reset), .busy(busy), .done(done)
  );

  retospect_bs_loader #(.CHAIN_LEN(11), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .start_load(start_load_s), .start_read(start_read_s),
    .abort(1'b0), .in_data(in_data_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(1'b0),
    .cfg_en(cfg_en_s), .cfg_bs_in(cfg_bs_in_s), .cfg_bs_out(1'b0),
    .nn_reset(nn_reset_s), .busy(busy_s), .done(done_s)
  );

  // Behavioural chain: new bits enter at the head, the tail feeds cfg_bs_out.
  logic [N-1:0] chain = '0;
  int en_total = 0, nn_total = 0, done_total = 0, fetch_en_total = 0, emit_en_total = 0;
  assign cfg_bs_out = chain[0];
  always @(posedge clk) begin
    if (cfg_en) begin
      chain    <= {cfg_bs_in, chain[N-1:1]};
      en_total <= en_total + 1;
    end
    if (nn_reset)            nn_total       <= nn_total + 1;
    if (done)                done_total     <= done_total + 1;
    if (cfg_en && in_ready)  fetch_en_total <= fetch_en_total + 1;
    if (cfg_en && out_valid) emit_en_total  <= emit_en_total + 1;
  end

  int checks = 0, errors = 0;
  logic [7:0]   bytes [NB];
  logic [N-1:0] exp_chain;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_load(input bit gaps, input bit inv, input int abort_byte, output int cycles);
    int  idx, gap, after;
    bit  hs, stop;
    idx = 0; after = -1; stop = 1'b0; cycles = 0;
    gap = gaps ? int'($urandom_range(5, 0)) : 0;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    while (!done && !stop && cycles < 4000) begin
      hs = 1'b0;
      if (after == 0) begin
        abort = 1'b1;
        stop  = 1'b1;
      end else if (in_ready && gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = 1'b1;
        in_data  = (idx < NB) ? (inv ? ~bytes[idx] : bytes[idx]) : 8'h00;
        hs       = in_ready;
      end
      tick();
      cycles++;
      if (after > 0) after--;
      if (hs) begin
        if (idx == abort_byte) after = 3;
        idx++;
        gap = gaps ? int'($urandom_range(5, 0)) : 0;
      end
    end
    abort    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic run_read(input bit stall, output int bad, output int unstable, output int nbytes);
    int         cyc;
    bit         prev_stall;
    logic [7:0] prev_data, exp;
    bad = 0; unstable = 0; nbytes = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    while (nbytes < NB && cyc < 6000) begin
      out_ready = stall ? (cyc % 3 == 2) : 1'b1;
      if (out_valid) begin
        if (prev_stall && out_data !== prev_data) unstable++;
        if (out_ready) begin
          exp = (nbytes == NB - 1) ? (bytes[nbytes] & 8'h3F) : bytes[nbytes];
          if (out_data !== exp) bad++;
          nbytes++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_data  = out_data;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int          cyc, bad, unst, nb, idx_s, nbit;
    int          en_b, nn_b, done_b, fetch_b, emit_b;
    logic [14:0] en_pat, nn_pat, done_pat;
    logic [10:0] stream;
    logic [7:0]  b;

    reset = 1'b1; start_load = 0; start_read = 0; abort = 0; in_valid = 0;
    in_data = 0; out_ready = 0;
    start_load_s = 0; start_read_s = 0; in_valid_s = 0; in_data_s = 0;
    for (int i = 0; i < NB; i++) bytes[i] = 8'($urandom_range(255, 0));
    for (int k = 0; k < N; k++) begin
      b = bytes[k / 8];
      exp_chain[k] = b[k % 8];
    end

    tick(); tick();
    check("reset_outs", {in_ready, out_valid, out_data, cfg_en, cfg_bs_in, nn_reset, busy, done}, 0);
    check("reset_outs_s", {in_ready_s, out_valid_s, out_data_s, cfg_en_s, cfg_bs_in_s,
                           nn_reset_s, busy_s, done_s}, 0);
    reset = 1'b0;
    tick();

    // Short chain: both starts together, start_read again while busy.
    start_load_s = 1'b1; start_read_s = 1'b1; in_valid_s = 1'b1;
    tick();
    start_load_s = 1'b0; start_read_s = 1'b0;
    check("both_starts_load_wins", {in_ready_s, cfg_en_s, busy_s}, 3'b101);
    idx_s = 0; nbit = 0; en_pat = '0; nn_pat = '0; done_pat = '0; stream = '0;
    for (int i = 0; i < 15; i++) begin
      en_pat[i]   = cfg_en_s;
      nn_pat[i]   = nn_reset_s;
      done_pat[i] = done_s;
      if (cfg_en_s && nbit < 11) begin
        stream[nbit] = cfg_bs_in_s;
        nbit++;
      end
      if (in_ready_s) begin
        in_data_s = (idx_s == 0) ? 8'hA5 : (idx_s == 1) ? 8'h03 : 8'hFF;
        idx_s++;
      end
      start_read_s = (i == 5);
      tick();
    end
    in_valid_s = 1'b0;
    check("short_bitstream", stream, 11'h3A5);
    check("short_en_bursts", en_pat, 15'h1DFE);
    check("short_nn_reset", nn_pat, 15'h2000);
    check("short_done", done_pat, 15'h2000);
    check("short_idle_after", {busy_s, cfg_en_s}, 2'b00);

    // Full-length load, in_valid held high.
    en_b = en_total; nn_b = nn_total; fetch_b = fetch_en_total;
    run_load(1'b0, 1'b0, -1, cyc);
    check("load_cycles", cyc, 1123);
    check("load_pulse", {nn_reset, done, cfg_en}, 3'b110);
    check("load_en_count", en_total - en_b, N);
    check("load_chain", chain === exp_chain, 1);
    check("load_no_en_in_fetch", fetch_en_total - fetch_b, 0);
    tick();
    check("load_idle_after", {busy, nn_reset, done}, 3'b000);
    check("load_nn_count", nn_total - nn_b, 1);

    // Readback with out_ready always high.
    en_b = en_total; nn_b = nn_total;
    run_read(1'b0, bad, unst, nb);
    check("read_done_pulse", {done, busy}, 2'b10);
    check("read_byte_count", nb, NB);
    check("read_byte_mismatches", bad, 0);
    check("read_en_count", en_total - en_b, N);
    check("read_chain_unchanged", chain === exp_chain, 1);
    check("read_no_nn_reset", nn_total - nn_b, 0);
    tick();
    check("read_done_one_cycle", done, 1'b0);

    // Abort in the middle of byte 3 of an inverted-data load.
    nn_b = nn_total; done_b = done_total;
    run_load(1'b0, 1'b1, 3, cyc);
    check("abort_idle_next", {busy, cfg_en, nn_reset, done}, 4'b0000);
    tick(); tick(); tick();
    check("abort_no_nn_reset", nn_total - nn_b, 0);
    check("abort_no_done", done_total - done_b, 0);
    check("abort_chain_disturbed", chain !== exp_chain, 1);

    // Gapped load after the abort restarts cleanly from byte 0.
    en_b = en_total; fetch_b = fetch_en_total;
    run_load(1'b1, 1'b0, -1, cyc);
    check("gap_load_done", {done, nn_reset}, 2'b11);
    check("gap_en_count", en_total - en_b, N);
    check("gap_no_en_in_fetch", fetch_en_total - fetch_b, 0);
    check("gap_chain", chain === exp_chain, 1);
    tick();

    // Readback with out_ready high one cycle in three.
    en_b = en_total; emit_b = emit_en_total;
    run_read(1'b1, bad, unst, nb);
    check("stall_done_pulse", {done, busy}, 2'b10);
    check("stall_byte_count", nb, NB);
    check("stall_byte_mismatches", bad, 0);
    check("stall_out_data_stable", unst, 0);
    check("stall_no_en_in_emit", emit_en_total - emit_b, 0);
    check("stall_en_count", en_total - en_b, N);
    check("stall_chain_unchanged", chain === exp_chain, 1);
    tick();

    // Synchronous reset while shifting readback bits.
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    tick(); tick();
    check("rd_shift_active", {cfg_en, busy}, 2'b11);
    reset = 1'b1;
    tick();
    check("reset_mid_read", {in_ready, out_valid, out_data, cfg_en, cfg_bs_in, nn_reset, busy, done}, 0);
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
